sramlike_axi_bridge: RTL and testbench



---
 rtl/sramlike_axi_bridge.sv | 215 +++++++++++++++++++++
 tb/tb_sramlike_axi_bridge.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sramlike_axi_bridge.sv
// SRAM-like (inst + data) to AXI3 master bridge: one outstanding read, one outstanding write.
// Optional macro BRIDGE_RAW_CHECK_EN narrows the fetch-vs-pending-store block to a same-word match.
module sramlike_axi_bridge (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_B} w_state_t;

    r_state_t    r_state_q, r_state_d;
    w_state_t    w_state_q, w_state_d;

    logic [31:0] ar_addr_q, aw_addr_q, wdata_q, inst_rdata_q, data_rdata_q;
    logic [1:0]  ar_size_q, aw_size_q;
    logic [3:0]  wstrb_q;
    logic        rd_is_data_q, data_busy_q, aw_done_q, w_done_q;
    logic        inst_data_ok_q, data_data_ok_q;

    logic        data_rd_ok, data_wr_ok, wr_hazard;
    logic        rd_start_data, rd_start, wr_start;
    logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic        unused_inputs;

    assign unused_inputs = ^{inst_wr, inst_wdata, rid, rresp, rlast, bid, bresp};

    assign data_rd_ok = data_req & ~data_wr & ~data_busy_q & (r_state_q == R_IDLE);
    assign data_wr_ok = data_req &  data_wr & ~data_busy_q & (w_state_q == W_IDLE);

`ifdef BRIDGE_RAW_CHECK_EN
    assign wr_hazard = (w_state_q != W_IDLE) && (inst_addr[31:2] == aw_addr_q[31:2]);
`else
    assign wr_hazard = (w_state_q != W_IDLE);
`endif

    // resetn gates the combinational accepts so nothing is acknowledged while held in reset
    assign data_addr_ok = resetn & (data_rd_ok | data_wr_ok);
    assign inst_addr_ok = resetn & inst_req & (r_state_q == R_IDLE) & ~data_rd_ok & ~wr_hazard;

    assign rd_start_data = resetn & data_rd_ok;
    assign rd_start      = rd_start_data | inst_addr_ok;
    assign wr_start      = resetn & data_wr_ok;

    assign ar_hs = arvalid & arready;
    assign r_hs  = rready & rvalid;
    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign b_hs  = bready & bvalid;

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (rd_start) r_state_d = R_AR;
            R_AR:    if (ar_hs)    r_state_d = R_R;
            R_R:     if (r_hs)     r_state_d = R_IDLE;
            default:               r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (wr_start) w_state_d = W_AW;
            W_AW:    if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) w_state_d = W_B;
            W_B:     if (b_hs)     w_state_d = W_IDLE;
            default:               w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q      <= R_IDLE;
            w_state_q      <= W_IDLE;
            ar_addr_q      <= '0;
            ar_size_q      <= '0;
            rd_is_data_q   <= 1'b0;
            aw_addr_q      <= '0;
            aw_size_q      <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            inst_rdata_q   <= '0;
            data_rdata_q   <= '0;
            inst_data_ok_q <= 1'b0;
            data_data_ok_q <= 1'b0;
            data_busy_q    <= 1'b0;
        end else begin
            r_state_q      <= r_state_d;
            w_state_q      <= w_state_d;
            inst_data_ok_q <= 1'b0;
            data_data_ok_q <= 1'b0;

            if (rd_start) begin
                ar_addr_q    <= rd_start_data ? data_addr : inst_addr;
                ar_size_q    <= rd_start_data ? data_size : inst_size;
                rd_is_data_q <= rd_start_data;
            end
            if (r_hs) begin
                if (rd_is_data_q) begin
                    data_rdata_q   <= rdata;
                    data_data_ok_q <= 1'b1;
                end else begin
                    inst_rdata_q   <= rdata;
                    inst_data_ok_q <= 1'b1;
                end
            end

            if (wr_start) begin
                aw_addr_q <= data_addr;
                aw_size_q <= data_size;
                wdata_q   <= data_wdata;
                wstrb_q   <= data_wen;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else begin
                if (aw_hs) aw_done_q <= 1'b1;
                if (w_hs)  w_done_q  <= 1'b1;
            end
            if (b_hs) data_data_ok_q <= 1'b1;

            // Busy spans request acceptance up to the response edge, so the next data request
            // can be accepted in the same cycle data_data_ok pulses.
            if (data_addr_ok)                       data_busy_q <= 1'b1;
            else if ((r_hs & rd_is_data_q) | b_hs)  data_busy_q <= 1'b0;
        end
    end

    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;
    assign inst_data_ok = inst_data_ok_q;
    assign data_data_ok = data_data_ok_q;

    assign arid    = 4'd0;
    assign araddr  = ar_addr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, ar_size_q};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = (r_state_q == R_AR);
    assign rready  = (r_state_q == R_R);

    assign awid    = 4'd0;
    assign awaddr  = aw_addr_q;
    assign awlen   = 4'd0;
    assign awsize  = {1'b0, aw_size_q};
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = (w_state_q == W_AW) & ~aw_done_q;

    assign wid     = 4'd0;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign wvalid  = (w_state_q == W_AW) & ~w_done_q;
    assign bready  = (w_state_q == W_B);

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Directed bench for sramlike_axi_bridge: fetch, read priority, delayed store, fetch/store hazard, mid-read reset.
// Hazard expectations follow BRIDGE_RAW_CHECK_EN when the bench is built with it.
module tb_sramlike_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        inst_addr_ok, inst_data_ok;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wen;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;
    logic [3:0]  arid, arcache, rid, awid, awlen, awcache, wid, wstrb, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int passed = 0;
    int total  = 0;
    logic raw_exp;

    always #5 clk = ~clk;

    sramlike_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wen(data_wen),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
        data_req = 1; data_wr = 0; data_size = 2'd2; data_wen = 0; data_addr = 0; data_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
`ifdef BRIDGE_RAW_CHECK_EN
        raw_exp = 1'b1;
`else
        raw_exp = 1'b0;
`endif

        // Reset state, with a data request pending that must not be acknowledged
        tick; tick;
        chk("rst_data_addr_ok", data_addr_ok, 0);
        chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
        chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_wstrb", wstrb, 0);
        chk("rst_rdata", inst_rdata | data_rdata, 0);
        data_req = 0;
        resetn = 1'b1;
        tick;

        // Single fetch, zero-wait slave
        $display("txn1: fetch 1fc00000");
        rdata = 32'h3C1D0001; arready = 1; rvalid = 1; awready = 1; wready = 1;
        inst_req = 1; inst_addr = 32'h1FC00000; #1;
        chk("t1_inst_addr_ok", inst_addr_ok, 1);
        chk("t1_data_addr_ok", data_addr_ok, 0);
        tick; inst_req = 0; #1;
        chk("t1_arvalid", arvalid, 1);
        chk("t1_araddr", araddr, 32'h1FC00000);
        chk("t1_arsize", arsize, 3'd2);
        chk("t1_arlen", arlen, 0);
        tick;
        chk("t1_rready", rready, 1);
        chk("t1_arvalid_drop", arvalid, 0);
        tick;
        chk("t1_inst_data_ok", inst_data_ok, 1);
        chk("t1_inst_rdata", inst_rdata, 32'h3C1D0001);
        tick;
        chk("t1_inst_data_ok_pulse", inst_data_ok, 0);
        chk("t1_inst_rdata_hold", inst_rdata, 32'h3C1D0001);

        // Data read wins over a simultaneous fetch; fetch accepted when data_data_ok pulses
        $display("txn2: data read 00001000 vs fetch 1fc00004");
        rdata = 32'h11112222;
        inst_req = 1; inst_addr = 32'h1FC00004;
        data_req = 1; data_wr = 0; data_addr = 32'h00001000; #1;
        chk("t2_data_addr_ok", data_addr_ok, 1);
        chk("t2_inst_addr_ok", inst_addr_ok, 0);
        tick; data_req = 0; #1;
        chk("t2_araddr", araddr, 32'h00001000);
        chk("t2_inst_blocked_ar", inst_addr_ok, 0);
        tick;
        chk("t2_inst_blocked_r", inst_addr_ok, 0);
        tick; rdata = 32'h33334444; #1;
        chk("t2_data_data_ok", data_data_ok, 1);
        chk("t2_data_rdata", data_rdata, 32'h11112222);
        chk("t2_inst_addr_ok", inst_addr_ok, 1);
        tick; inst_req = 0; #1;
        chk("t2_inst_araddr", araddr, 32'h1FC00004);
        tick; tick;
        chk("t2_inst_data_ok", inst_data_ok, 1);
        chk("t2_inst_rdata", inst_rdata, 32'h33334444);
        chk("t2_data_rdata_hold", data_rdata, 32'h11112222);

        // Store with wready delayed four cycles
        $display("txn3: store 00002004 wen=0011");
        wready = 0; awready = 1; bvalid = 0;
        data_req = 1; data_wr = 1; data_addr = 32'h00002004; data_wen = 4'b0011;
        data_wdata = 32'hAABBCCDD; #1;
        chk("t3_data_addr_ok", data_addr_ok, 1);
        tick; data_req = 0; #1;
        chk("t3_aw_w_valid", {awvalid, wvalid}, 2'b11);
        chk("t3_awaddr", awaddr, 32'h00002004);
        chk("t3_wdata", wdata, 32'hAABBCCDD);
        chk("t3_wstrb", wstrb, 4'b0011);
        chk("t3_awsize", awsize, 3'd2);
        tick;
        chk("t3_aw_w_after_aw", {awvalid, wvalid}, 2'b01);
        tick; data_req = 1; data_wr = 0; data_addr = 32'h00005000; #1;
        chk("t3_busy_blocks_data", data_addr_ok, 0);
        data_req = 0;
        tick;
        chk("t3_wvalid_hold", wvalid, 1);
        tick; wready = 1; #1;
        chk("t3_w_before_hs", {wvalid, bready}, 2'b10);
        tick; wready = 0; bvalid = 1; #1;
        chk("t3_w_after_hs", {wvalid, bready}, 2'b01);
        chk("t3_no_early_ok", data_data_ok, 0);
        tick; bvalid = 0; #1;
        chk("t3_data_data_ok", data_data_ok, 1);
        chk("t3_bready_drop", bready, 0);
        tick;
        chk("t3_data_ok_pulse", data_data_ok, 0);

        // Fetch vs pending store hazard
        $display("txn4: store 00003000, fetches 00003000/00004000");
        awready = 1; wready = 1; bvalid = 0;
        data_req = 1; data_wr = 1; data_addr = 32'h00003000; data_wen = 4'hF;
        data_wdata = 32'h12345678; #1;
        chk("t4_data_addr_ok", data_addr_ok, 1);
        tick; data_req = 0; inst_req = 1; inst_addr = 32'h00003000; #1;
        chk("t4_same_word_aw", inst_addr_ok, 0);
        inst_addr = 32'h00004000; #1;
        chk("t4_other_word_aw", inst_addr_ok, raw_exp);
        inst_req = 0;
        tick; inst_req = 1; inst_addr = 32'h00003000; #1;
        chk("t4_same_word_b", inst_addr_ok, 0);
        inst_addr = 32'h00004000; #1;
        chk("t4_other_word_b", inst_addr_ok, raw_exp);
        inst_req = 0; bvalid = 1;
        tick; bvalid = 0; inst_req = 1; inst_addr = 32'h00003000; rdata = 32'h55556666; #1;
        chk("t4_store_done", data_data_ok, 1);
        chk("t4_fetch_released", inst_addr_ok, 1);
        tick; inst_req = 0;
        tick; tick;
        chk("t4_inst_data_ok", inst_data_ok, 1);
        chk("t4_inst_rdata", inst_rdata, 32'h55556666);

        // Reset while waiting in R_R
        $display("txn5: reset during read, then fetch 1fc00020");
        rvalid = 0;
        inst_req = 1; inst_addr = 32'h1FC00010; #1;
        chk("t5_inst_addr_ok", inst_addr_ok, 1);
        tick; inst_req = 0;
        tick;
        chk("t5_rready", rready, 1);
        resetn = 1'b0; #1;
        chk("t5_rst_valids", {rready, arvalid}, 0);
        chk("t5_rst_inst_data_ok", inst_data_ok, 0);
        chk("t5_rst_inst_rdata", inst_rdata, 0);
        tick; tick;
        resetn = 1'b1; rvalid = 1; rdata = 32'h77778888;
        tick; inst_req = 1; inst_addr = 32'h1FC00020; #1;
        chk("t5_post_addr_ok", inst_addr_ok, 1);
        tick; inst_req = 0; #1;
        chk("t5_post_araddr", araddr, 32'h1FC00020);
        tick; tick;
        chk("t5_post_inst_data_ok", inst_data_ok, 1);
        chk("t5_post_inst_rdata", inst_rdata, 32'h77778888);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
